// File: rtl/btn_conditioner_if.sv
// Press-event stream between the button front end and the game core.
// The master presents one encoded press at a time; the slave accepts it with evt_ready.
interface btn_conditioner_if #(
    parameter int CODE_W = 2
);
    logic              evt_valid;
    logic [CODE_W-1:0] evt_code;
    logic              evt_ready;
    logic              evt_overflow;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_overflow,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_overflow,
        output evt_ready
    );
endinterface

// File: rtl/btn_conditioner.sv
// Button front end: synchronizes and debounces raw pads, then emits one
// press pulse and one queued event per debounced rising edge.
module btn_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int CODE_W          = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  btn_raw,
    output logic [N_BTN-1:0]  btn_level,
    output logic [N_BTN-1:0]  btn_press,
    btn_conditioner_if.master evt
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0]  sync_meta;
    logic [N_BTN-1:0]  sync;
    logic [CNT_W-1:0]  cnt [N_BTN];
    logic [N_BTN-1:0]  flip;
    logic [N_BTN-1:0]  rise;
    logic [N_BTN-1:0]  pend;
    logic [N_BTN-1:0]  sel_mask;
    logic [N_BTN-1:0]  take_mask;
    logic [N_BTN-1:0]  drop;
    logic [CODE_W-1:0] sel_code;
    logic              sel_found;
    logic              slot_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync      <= sync_meta;
        end
    end

    // A button flips once its synchronized value has disagreed for the full window.
    always_comb begin
        flip = '0;
        for (int i = 0; i < N_BTN; i++) begin
            flip[i] = (sync[i] != btn_level[i]) && (cnt[i] == CNT_LAST);
        end
    end

    assign rise = flip & sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
            btn_level <= '0;
            btn_press <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if ((sync[i] == btn_level[i]) || flip[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            btn_level <= btn_level ^ flip;
            btn_press <= rise;
        end
    end

    always_comb begin
        sel_code  = '0;
        sel_mask  = '0;
        sel_found = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (pend[i] && !sel_found) begin
                sel_found   = 1'b1;
                sel_code    = CODE_W'(i);
                sel_mask[i] = 1'b1;
            end
        end
    end

    // A press landing on the bit being handed to the slot survives; only a
    // press onto a bit that stays pending is lost.
    assign slot_free = !evt.evt_valid || evt.evt_ready;
    assign take_mask = slot_free ? sel_mask : '0;
    assign drop      = rise & pend & ~take_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend             <= '0;
            evt.evt_valid    <= 1'b0;
            evt.evt_code     <= '0;
            evt.evt_overflow <= 1'b0;
        end else begin
            pend <= (pend & ~take_mask) | rise;
            if (|drop) begin
                evt.evt_overflow <= 1'b1;
            end
            if (slot_free) begin
                evt.evt_valid <= sel_found;
                if (sel_found) begin
                    evt.evt_code <= sel_code;
                end
            end
        end
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed tables and sequences plus
// random stimulus, all compared against a sliding-window reference model.
module tb_btn_conditioner;
    localparam int N = 4;
    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;

    btn_conditioner_if #(.CODE_W(2)) evt_bus ();

    btn_conditioner #(
        .N_BTN(N),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3),
        .CODE_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .evt(evt_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: a button flips when the last D synchronized samples all
    // disagree with its level; pending presses form a set drained lowest-first.
    logic [3:0] hist [$];
    logic [3:0] m_level, m_press, m_pend;
    logic       m_valid, m_over;
    logic [1:0] m_code;

    typedef struct {
        logic [3:0] raw;
        logic       ready;
        logic [3:0] level;
        logic [3:0] press;
        logic       valid;
        logic [1:0] code;
    } vec_t;

    vec_t vecs [9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic modelReset();
        hist.delete();
        for (int k = 0; k < D + 2; k++) hist.push_back(4'h0);
        m_level = '0;
        m_press = '0;
        m_pend  = '0;
        m_valid = 1'b0;
        m_over  = 1'b0;
        m_code  = '0;
    endtask

    task automatic modelStep(input logic [3:0] raw, input logic rdy, input logic r);
        logic [3:0] rise;
        logic       all_diff;
        int         idx;
        if (r) begin
            modelReset();
            return;
        end
        rise = '0;
        for (int i = 0; i < N; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) begin
                if (hist[hist.size() - 2 - j][i] == m_level[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_level[i] = ~m_level[i];
                rise[i]    = m_level[i];
            end
        end
        m_press = rise;
        if (!m_valid || rdy) begin
            if (m_pend != 0) begin
                idx = 0;
                for (int i = N - 1; i >= 0; i--) if (m_pend[i]) idx = i;
                m_code       = 2'(idx);
                m_valid      = 1'b1;
                m_pend[idx]  = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
        if ((m_pend & rise) != 0) m_over = 1'b1;
        m_pend = m_pend | rise;
        hist.push_back(raw);
        if (hist.size() > D + 4) void'(hist.pop_front());
    endtask

    task automatic applyStimulus(input logic [3:0] raw, input logic rdy, input logic r);
        btn_raw           = raw;
        evt_bus.evt_ready = rdy;
        rst               = r;
        @(posedge clk);
        #1;
        cycle++;
        modelStep(raw, rdy, r);
        checkOutput("model",
                    {btn_level, btn_press, evt_bus.evt_valid, evt_bus.evt_code, evt_bus.evt_overflow},
                    {m_level, m_press, m_valid, m_code, m_over});
    endtask

    task automatic hold(input logic [3:0] raw, input logic rdy, input int n);
        for (int k = 0; k < n; k++) applyStimulus(raw, rdy, 1'b0);
    endtask

    initial begin
        logic [3:0] cur_raw;
        int         accepts;

        btn_raw           = 4'hF;
        evt_bus.evt_ready = 1'b1;
        rst               = 1'b1;
        modelReset();

        for (int k = 0; k < 9; k++) begin
            vecs[k].raw   = 4'b0010;
            vecs[k].ready = 1'b1;
            vecs[k].level = (k >= 5) ? 4'b0010 : 4'b0000;
            vecs[k].press = (k == 5) ? 4'b0010 : 4'b0000;
            vecs[k].valid = (k == 6);
            vecs[k].code  = 2'd1;
        end

        // Reset with all pads held high.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'hF, 1'b1, 1'b1);
            checkOutput("reset_outputs",
                        {btn_level, btn_press, evt_bus.evt_valid, evt_bus.evt_code, evt_bus.evt_overflow}, 0);
        end
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(4'hF, 1'b1, 1'b0);
            checkOutput("reset_release_level", btn_level, (k == 6) ? 4'hF : 4'h0);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'hF, 1'b1, 1'b0);
            checkOutput("drain_valid", evt_bus.evt_valid, 1);
            checkOutput("drain_code", evt_bus.evt_code, k);
        end
        applyStimulus(4'hF, 1'b1, 1'b0);
        checkOutput("drain_empty", evt_bus.evt_valid, 0);
        hold(4'h0, 1'b1, 8);

        // Clean press on button 1.
        for (int k = 0; k < 9; k++) begin
            applyStimulus(vecs[k].raw, vecs[k].ready, 1'b0);
            checkOutput("clean_level", btn_level, vecs[k].level);
            checkOutput("clean_press", btn_press, vecs[k].press);
            checkOutput("clean_valid", evt_bus.evt_valid, vecs[k].valid);
            if (vecs[k].valid) checkOutput("clean_code", evt_bus.evt_code, vecs[k].code);
        end
        hold(4'h0, 1'b1, 8);

        // Bounce on button 0 is rejected.
        applyStimulus(4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
            checkOutput("bounce_quiet", {btn_level, btn_press, evt_bus.evt_valid}, 0);
        end

        // Simultaneous presses stalled, then delivered in ascending order.
        hold(4'b1101, 1'b0, 7);
        checkOutput("simul_first_valid", evt_bus.evt_valid, 1);
        checkOutput("simul_first_code", evt_bus.evt_code, 0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b1101, 1'b0, 1'b0);
            checkOutput("simul_stall_code", {evt_bus.evt_valid, evt_bus.evt_code}, {1'b1, 2'd0});
        end
        applyStimulus(4'b1101, 1'b1, 1'b0);
        checkOutput("simul_code2", {evt_bus.evt_valid, evt_bus.evt_code}, {1'b1, 2'd2});
        applyStimulus(4'b1101, 1'b1, 1'b0);
        checkOutput("simul_code3", {evt_bus.evt_valid, evt_bus.evt_code}, {1'b1, 2'd3});
        applyStimulus(4'b1101, 1'b1, 1'b0);
        checkOutput("simul_empty", evt_bus.evt_valid, 0);
        hold(4'h0, 1'b1, 8);

        // Overflow: three presses of button 2 with the consumer stalled.
        hold(4'b0100, 1'b0, 7);
        checkOutput("ovf_slot", {evt_bus.evt_valid, evt_bus.evt_code}, {1'b1, 2'd2});
        hold(4'b0000, 1'b0, 7);
        hold(4'b0100, 1'b0, 7);
        checkOutput("ovf_not_yet", evt_bus.evt_overflow, 0);
        hold(4'b0000, 1'b0, 7);
        hold(4'b0100, 1'b0, 7);
        checkOutput("ovf_set", evt_bus.evt_overflow, 1);
        accepts = 0;
        for (int k = 0; k < 6; k++) begin
            if (evt_bus.evt_valid && evt_bus.evt_code == 2'd2) accepts++;
            applyStimulus(4'b0000, 1'b1, 1'b0);
        end
        checkOutput("ovf_accepts", accepts, 2);
        checkOutput("ovf_sticky", evt_bus.evt_overflow, 1);

        // Reset while an event is held and another is pending.
        hold(4'b0011, 1'b0, 7);
        checkOutput("midrst_valid", evt_bus.evt_valid, 1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("midrst_outputs",
                    {btn_level, btn_press, evt_bus.evt_valid, evt_bus.evt_code, evt_bus.evt_overflow}, 0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
            checkOutput("midrst_no_stale", evt_bus.evt_valid, 0);
        end

        // Random pads and consumer back-pressure against the model.
        cur_raw = 4'h0;
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) cur_raw[i] = ~cur_raw[i];
            end
            applyStimulus(cur_raw, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
